// File: rtl/wb_burst_master.sv
// wb_burst_master: Wishbone classic-cycle burst initiator.
// One accepted command (start address, beat count, direction) becomes an
// incrementing burst (CTI 010, last beat 111). Write beats come from a
// valid/ready stream. Read beats leave on a valid-only stream.
// A per-beat watchdog aborts a beat that is never acknowledged.
`timescale 1ns/1ps

module wb_burst_master #(
    parameter int AW  = 26,
    parameter int DW  = 32,
    parameter int BW  = 4,
    parameter int TMO = 255
) (
    input  logic          sys_clk,
    input  logic          RESETN,
    input  logic          sdr_init_done,
    // Handshake rule for cmd_* and wr_*: a transfer happens on the rising
    // edge where valid and ready are both high. valid must not wait for
    // ready. ready is registered and never depends on valid in the same
    // cycle. rd_valid has no ready: the consumer must take every pulse.
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic          cmd_we,
    input  logic [AW-1:0] cmd_addr,
    input  logic [7:0]    cmd_len,
    input  logic [DW-1:0] wr_data,
    input  logic          wr_valid,
    output logic          wr_ready,
    output logic [DW-1:0] rd_data,
    output logic          rd_valid,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic          wb_cyc_o,
    output logic          wb_stb_o,
    output logic          wb_we_o,
    output logic [AW-1:0] wb_addr_o,
    output logic [DW-1:0] wb_dat_o,
    output logic [BW-1:0] wb_sel_o,
    output logic [2:0]    wb_cti_o,
    input  logic          wb_ack_i,
    input  logic [DW-1:0] wb_dat_i,
    output logic [2:0]    dbg_state_o
);

    localparam int WDW = (TMO > 2) ? $clog2(TMO) : 1;
    localparam logic [WDW-1:0] WDOG_LAST = WDW'(TMO - 1);
    localparam logic [AW-1:0]  ADDR_STEP = AW'(BW);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WR_LOAD = 3'd1,
        S_WR_BEAT = 3'd2,
        S_RD_BEAT = 3'd3,
        S_FIN     = 3'd4
    } state_e;

    state_e          state_q;
    logic [AW-1:0]   addr_q;
    logic [7:0]      cnt_q;
    logic [DW-1:0]   dat_q;
    logic [DW-1:0]   rd_data_q;
    logic [WDW-1:0]  wdog_q;
    logic            cmd_ready_q;
    logic            wr_ready_q;
    logic            rd_valid_q;
    logic            busy_q;
    logic            done_q;
    logic            err_q;
    logic            cyc_q;
    logic            stb_q;
    logic            we_q;

    logic [AW-1:0]   addr_d;
    logic [7:0]      cnt_d;
    logic [WDW-1:0]  wdog_d;
    logic            last_beat;
    logic            tmo_hit;

    // Next beat address (wraps modulo 2^AW), remaining count and watchdog.
    always_comb begin
        addr_d    = addr_q + ADDR_STEP;
        cnt_d     = cnt_q - 8'd1;
        last_beat = (cnt_q == 8'd0);
        tmo_hit   = stb_q && !wb_ack_i && (wdog_q == WDOG_LAST);
        if (stb_q && !wb_ack_i) begin
            wdog_d = wdog_q + WDW'(1);
        end else begin
            wdog_d = '0;
        end
    end

    // Burst sequencer: every output below is a register updated here.
    always_ff @(posedge sys_clk or negedge RESETN) begin
        if (!RESETN) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            cnt_q       <= '0;
            dat_q       <= '0;
            rd_data_q   <= '0;
            wdog_q      <= '0;
            cmd_ready_q <= 1'b0;
            wr_ready_q  <= 1'b0;
            rd_valid_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            cyc_q       <= 1'b0;
            stb_q       <= 1'b0;
            we_q        <= 1'b0;
        end else begin
            rd_valid_q <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            wdog_q     <= wdog_d;
            case (state_q)
                S_IDLE: begin
                    cmd_ready_q <= sdr_init_done;
                    if (cmd_valid && cmd_ready_q) begin
                        cmd_ready_q <= 1'b0;
                        addr_q      <= cmd_addr;
                        cnt_q       <= cmd_len;
                        busy_q      <= 1'b1;
                        cyc_q       <= 1'b1;
                        if (cmd_we) begin
                            wr_ready_q <= 1'b1;
                            state_q    <= S_WR_LOAD;
                        end else begin
                            stb_q   <= 1'b1;
                            we_q    <= 1'b0;
                            state_q <= S_RD_BEAT;
                        end
                    end
                end
                S_WR_LOAD: begin
                    // Acks arriving here (stb low) are ignored.
                    if (wr_valid) begin
                        dat_q      <= wr_data;
                        wr_ready_q <= 1'b0;
                        stb_q      <= 1'b1;
                        we_q       <= 1'b1;
                        state_q    <= S_WR_BEAT;
                    end
                end
                S_WR_BEAT: begin
                    if (wb_ack_i) begin
                        stb_q <= 1'b0;
                        we_q  <= 1'b0;
                        if (last_beat) begin
                            cyc_q   <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= S_FIN;
                        end else begin
                            cnt_q      <= cnt_d;
                            addr_q     <= addr_d;
                            wr_ready_q <= 1'b1;
                            state_q    <= S_WR_LOAD;
                        end
                    end else if (tmo_hit) begin
                        cyc_q   <= 1'b0;
                        stb_q   <= 1'b0;
                        we_q    <= 1'b0;
                        busy_q  <= 1'b0;
                        err_q   <= 1'b1;
                        state_q <= S_IDLE;
                    end
                end
                S_RD_BEAT: begin
                    if (wb_ack_i) begin
                        rd_data_q  <= wb_dat_i;
                        rd_valid_q <= 1'b1;
                        addr_q     <= addr_d;
                        if (last_beat) begin
                            cyc_q   <= 1'b0;
                            stb_q   <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= S_FIN;
                        end else begin
                            cnt_q <= cnt_d;
                        end
                    end else if (tmo_hit) begin
                        cyc_q   <= 1'b0;
                        stb_q   <= 1'b0;
                        busy_q  <= 1'b0;
                        err_q   <= 1'b1;
                        state_q <= S_IDLE;
                    end
                end
                S_FIN: begin
                    busy_q      <= 1'b0;
                    cmd_ready_q <= sdr_init_done;
                    state_q     <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign cmd_ready   = cmd_ready_q;
    assign wr_ready    = wr_ready_q;
    assign rd_data     = rd_data_q;
    assign rd_valid    = rd_valid_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign err         = err_q;
    assign wb_cyc_o    = cyc_q;
    assign wb_stb_o    = stb_q;
    assign wb_we_o     = we_q;
    assign wb_addr_o   = addr_q;
    assign wb_dat_o    = dat_q;
    assign wb_sel_o    = {BW{cyc_q}};
    assign wb_cti_o    = !cyc_q ? 3'b000 : (last_beat ? 3'b111 : 3'b010);
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_wb_burst_master.sv
// Bench for wb_burst_master: Wishbone slave model with programmable ack
// delay, a reference model of bursts (address list, CTI, data) and
// scenario tasks called in sequence.
`timescale 1ns/1ps

module tb_wb_burst_master;

    localparam int AW  = 26;
    localparam int DW  = 32;
    localparam int BW  = 4;
    localparam int TMO = 255;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [2:0]    cti;
        logic [BW-1:0] sel;
        logic          we;
        logic [DW-1:0] dat;
    } beat_t;

    // ---------------- clock / reset ----------------
    logic          sys_clk = 1'b0;
    logic          RESETN = 1'b0;
    logic          sdr_init_done = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_we = 1'b0;
    logic [AW-1:0] cmd_addr = '0;
    logic [7:0]    cmd_len = '0;
    logic [DW-1:0] wr_data = '0;
    logic          wr_valid = 1'b0;
    logic          wb_ack_i = 1'b0;
    logic [DW-1:0] wb_dat_i = '0;
    logic          cmd_ready, wr_ready, rd_valid, busy, done, err;
    logic [DW-1:0] rd_data, wb_dat_o;
    logic          wb_cyc_o, wb_stb_o, wb_we_o;
    logic [AW-1:0] wb_addr_o;
    logic [BW-1:0] wb_sel_o;
    logic [2:0]    wb_cti_o;
    logic [2:0]    dbg_state_o;

    always #5 sys_clk = ~sys_clk;

    wb_burst_master #(.AW(AW), .DW(DW), .BW(BW), .TMO(TMO)) dut (
        .sys_clk(sys_clk), .RESETN(RESETN), .sdr_init_done(sdr_init_done),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .rd_data(rd_data), .rd_valid(rd_valid),
        .busy(busy), .done(done), .err(err),
        .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
        .wb_addr_o(wb_addr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o),
        .wb_cti_o(wb_cti_o), .wb_ack_i(wb_ack_i), .wb_dat_i(wb_dat_i),
        .dbg_state_o(dbg_state_o)
    );

    // ---------------- scoreboard state ----------------
    int checks = 0;
    int errors = 0;

    beat_t         exp_q[$];
    beat_t         obs_q[$];
    logic [DW-1:0] exp_rd[$];
    logic [DW-1:0] obs_rd[$];
    logic [DW-1:0] wq[$];
    logic [DW-1:0] model_mem [logic [AW-1:0]];
    logic [DW-1:0] slave_mem [logic [AW-1:0]];

    int  ack_delay = 0;
    bit  no_ack = 0;
    bit  stray_en = 0;
    int  wait_cnt = 0;
    int  cyc_n = 0;
    int  last_ack_n = -100;
    int  done_n = -1;
    int  done_cnt = 0;
    int  err_cnt = 0;
    int  stall_cnt = 0;
    int  err_stall = 0;
    bit  err_cyc_low = 0;
    bit  wack_pending = 0;
    bit  burst_timed_out = 0;
    logic rdy_after = 1'b0;

    // Contents of never-written slave locations.
    function automatic logic [DW-1:0] fill(input logic [AW-1:0] a);
        return {6'h2A, a};
    endfunction

    // Monitor and slave responder; everything happens on the falling edge.
    always @(negedge sys_clk) begin
        beat_t b;
        cyc_n++;
        if (rd_valid) obs_rd.push_back(rd_data);
        if (done) begin
            done_cnt++;
            done_n = cyc_n;
        end
        if (err) begin
            err_cnt++;
            err_stall = stall_cnt;
            err_cyc_low = !wb_cyc_o && !wb_stb_o && !busy;
        end
        if (wb_stb_o) stall_cnt++;
        if (wack_pending) begin
            wack_pending = 0;
            checks++;
            if (wr_ready !== 1'b1) begin
                errors++;
                $display("FAIL wr_ready_after_ack: got %b expected 1", wr_ready);
            end
        end
        wb_ack_i = 1'b0;
        if (RESETN && wb_cyc_o && wb_stb_o && !no_ack) begin
            if (wait_cnt < ack_delay) begin
                wait_cnt++;
            end else begin
                wait_cnt = 0;
                wb_ack_i = 1'b1;
                b.addr = wb_addr_o;
                b.cti  = wb_cti_o;
                b.sel  = wb_sel_o;
                b.we   = wb_we_o;
                b.dat  = wb_we_o ? wb_dat_o : '0;
                obs_q.push_back(b);
                if (wb_we_o) slave_mem[wb_addr_o] = wb_dat_o;
                else wb_dat_i = slave_mem.exists(wb_addr_o) ? slave_mem[wb_addr_o] : fill(wb_addr_o);
                if (wb_cti_o == 3'b111) last_ack_n = cyc_n;
                else if (wb_we_o) wack_pending = 1;
            end
        end else begin
            wait_cnt = 0;
            if (RESETN && stray_en && wb_cyc_o && !wb_stb_o && $urandom_range(0, 1) == 1)
                wb_ack_i = 1'b1;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(negedge sys_clk);
        #1;
    endtask

    task automatic send_cmd(input logic we, input logic [AW-1:0] addr, input logic [7:0] len);
        int t;
        cmd_valid = 1'b1;
        cmd_we    = we;
        cmd_addr  = addr;
        cmd_len   = len;
        t = 0;
        while (!cmd_ready && t < 200) begin
            tick();
            t++;
        end
        if (!cmd_ready) burst_timed_out = 1;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic feed_beat(input logic [DW-1:0] d, input int gap_max);
        int t;
        repeat ($urandom_range(0, gap_max)) begin
            wr_valid = 1'b0;
            tick();
        end
        wr_valid = 1'b1;
        wr_data  = d;
        t = 0;
        while (!wr_ready && t < 400) begin
            tick();
            t++;
        end
        if (!wr_ready) burst_timed_out = 1;
        tick();
        wr_valid = 1'b0;
    endtask

    task automatic wait_end();
        int t;
        t = 0;
        while (done_cnt == 0 && err_cnt == 0 && t < 2000) begin
            tick();
            t++;
        end
        if (done_cnt == 0 && err_cnt == 0) burst_timed_out = 1;
        tick();
        rdy_after = cmd_ready;
    endtask

    // Reference model: a burst of len+1 beats from addr, step BW modulo
    // 2^AW, CTI 111 only on the final beat, all byte lanes selected.
    task automatic run_burst(input logic we, input logic [AW-1:0] addr, input int len, input int gap_max);
        logic [AW-1:0] a;
        beat_t b;
        exp_q.delete(); exp_rd.delete(); obs_q.delete(); obs_rd.delete();
        done_cnt = 0; err_cnt = 0; stall_cnt = 0; burst_timed_out = 0;
        last_ack_n = -100; done_n = -1;
        while (wq.size() < len + 1) wq.push_back($urandom);
        for (int i = 0; i <= len; i++) begin
            a = addr + AW'(i * BW);
            b.addr = a;
            b.cti  = (i == len) ? 3'b111 : 3'b010;
            b.sel  = '1;
            b.we   = we;
            b.dat  = we ? wq[i] : '0;
            exp_q.push_back(b);
            if (we) model_mem[a] = wq[i];
            else exp_rd.push_back(model_mem.exists(a) ? model_mem[a] : fill(a));
        end
        send_cmd(we, addr, 8'(len));
        if (we) begin
            for (int i = 0; i <= len && !burst_timed_out; i++) feed_beat(wq[i], gap_max);
        end
        wq.delete();
        wait_end();
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        RESETN = 1'b0;
        for (int i = 0; i < 6; i++) begin
            cmd_valid = 1'($urandom_range(0, 1));
            cmd_we = 1'($urandom_range(0, 1));
            cmd_addr = AW'($urandom);
            cmd_len = 8'($urandom);
            wr_valid = 1'($urandom_range(0, 1));
            wr_data = $urandom;
            sdr_init_done = 1'($urandom_range(0, 1));
            tick();
            checks++;
            if ({cmd_ready, wr_ready, rd_valid, busy, done, err, wb_cyc_o, wb_stb_o, wb_we_o} !== 9'd0) begin
                errors++;
                $display("FAIL reset_ctrl: got %b expected 0",
                         {cmd_ready, wr_ready, rd_valid, busy, done, err, wb_cyc_o, wb_stb_o, wb_we_o});
            end
            checks++;
            if ({wb_addr_o, wb_dat_o, rd_data, wb_sel_o, wb_cti_o, dbg_state_o} !== '0) begin
                errors++;
                $display("FAIL reset_data: addr %h dat %h rd %h sel %h cti %b st %0d expected all 0",
                         wb_addr_o, wb_dat_o, rd_data, wb_sel_o, wb_cti_o, dbg_state_o);
            end
        end
        cmd_valid = 1'b0; wr_valid = 1'b0; sdr_init_done = 1'b0;
        tick();
        RESETN = 1'b1;
        tick();
    endtask

    task automatic test_init_gate();
        int t;
        obs_q.delete(); obs_rd.delete(); done_cnt = 0; err_cnt = 0;
        cmd_valid = 1'b1; cmd_we = 1'b0; cmd_addr = 26'h300; cmd_len = 8'd1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (cmd_ready !== 1'b0 || wb_cyc_o !== 1'b0) begin
                errors++;
                $display("FAIL init_gate_low: cmd_ready %b cyc %b expected 0 0", cmd_ready, wb_cyc_o);
            end
        end
        sdr_init_done = 1'b1;
        tick();
        checks++;
        if (cmd_ready !== 1'b1 || wb_cyc_o !== 1'b0) begin
            errors++;
            $display("FAIL init_gate_ready: cmd_ready %b cyc %b expected 1 0", cmd_ready, wb_cyc_o);
        end
        tick();
        cmd_valid = 1'b0;
        checks++;
        if ({wb_cyc_o, wb_stb_o, busy, wb_we_o} !== 4'b1110) begin
            errors++;
            $display("FAIL init_gate_accept: cyc/stb/busy/we %b expected 1110", {wb_cyc_o, wb_stb_o, busy, wb_we_o});
        end
        t = 0;
        while (done_cnt == 0 && t < 100) begin
            tick();
            t++;
        end
        checks++;
        if (obs_rd.size() !== 2 || done_cnt !== 1) begin
            errors++;
            $display("FAIL init_gate_burst: beats %0d done %0d expected 2 1", obs_rd.size(), done_cnt);
        end else begin
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (obs_rd[i] !== fill(AW'(32'h300 + i * BW))) begin
                    errors++;
                    $display("FAIL init_gate_rd%0d: got %h expected %h", i, obs_rd[i], fill(AW'(32'h300 + i * BW)));
                end
            end
        end
        tick();
    endtask

    task automatic test_single_write();
        ack_delay = 0;
        wq.push_back(32'hA5A5_0001);
        run_burst(1'b1, 26'h100, 0, 0);
        checks++;
        if (burst_timed_out || obs_q.size() !== 1) begin
            errors++;
            $display("FAIL single_wr_beats: got %0d timeout %0d expected 1 0", obs_q.size(), burst_timed_out);
        end else begin
            checks++;
            if (obs_q[0] !== exp_q[0]) begin
                errors++;
                $display("FAIL single_wr_beat: got %h expected %h", obs_q[0], exp_q[0]);
            end
        end
        checks++;
        if (done_cnt !== 1 || done_n !== last_ack_n + 1 || rdy_after !== 1'b1) begin
            errors++;
            $display("FAIL single_wr_done: done %0d at %0d ack %0d ready_after %b expected 1 at ack+1 ready 1",
                     done_cnt, done_n, last_ack_n, rdy_after);
        end
    endtask

    task automatic test_write_read();
        ack_delay = 2;
        run_burst(1'b1, 26'h200, 3, 2);
        checks++;
        if (burst_timed_out || obs_q.size() !== exp_q.size() || done_cnt !== 1) begin
            errors++;
            $display("FAIL wr4_beats: got %0d done %0d expected %0d 1", obs_q.size(), done_cnt, exp_q.size());
        end
        foreach (exp_q[i]) begin
            if (i < obs_q.size()) begin
                checks++;
                if (obs_q[i] !== exp_q[i]) begin
                    errors++;
                    $display("FAIL wr4_beat%0d: got %h expected %h", i, obs_q[i], exp_q[i]);
                end
            end
        end
        run_burst(1'b0, 26'h200, 3, 0);
        checks++;
        if (burst_timed_out || obs_rd.size() !== 4 || done_n !== last_ack_n + 1) begin
            errors++;
            $display("FAIL rd4_count: got %0d done_at %0d ack_at %0d expected 4 ack+1", obs_rd.size(), done_n, last_ack_n);
        end
        foreach (exp_q[i]) begin
            if (i < obs_q.size()) begin
                checks++;
                if (obs_q[i] !== exp_q[i]) begin
                    errors++;
                    $display("FAIL rd4_beat%0d: got %h expected %h", i, obs_q[i], exp_q[i]);
                end
            end
        end
        foreach (exp_rd[i]) begin
            if (i < obs_rd.size()) begin
                checks++;
                if (obs_rd[i] !== exp_rd[i]) begin
                    errors++;
                    $display("FAIL rd4_data%0d: got %h expected %h", i, obs_rd[i], exp_rd[i]);
                end
            end
        end
    endtask

    task automatic test_wrap();
        logic [AW-1:0] zero_addr;
        zero_addr = '0;
        ack_delay = 0;
        run_burst(1'b0, 26'h3FF_FFF8, 3, 0);
        checks++;
        if (burst_timed_out || obs_q.size() !== 4 || done_cnt !== 1) begin
            errors++;
            $display("FAIL wrap_beats: got %0d done %0d expected 4 1", obs_q.size(), done_cnt);
        end else begin
            checks++;
            if (obs_q[2].addr !== zero_addr) begin
                errors++;
                $display("FAIL wrap_zero: got %h expected %h", obs_q[2].addr, zero_addr);
            end
            foreach (exp_q[i]) begin
                checks++;
                if (obs_q[i] !== exp_q[i] || obs_rd[i] !== exp_rd[i]) begin
                    errors++;
                    $display("FAIL wrap_beat%0d: got %h/%h expected %h/%h", i, obs_q[i], obs_rd[i], exp_q[i], exp_rd[i]);
                end
            end
        end
    endtask

    task automatic test_timeout();
        no_ack = 1;
        run_burst(1'b0, 26'h800, 2, 0);
        repeat (3) tick();
        checks++;
        if (burst_timed_out || err_cnt !== 1 || done_cnt !== 0 || obs_q.size() !== 0) begin
            errors++;
            $display("FAIL tmo_pulse: err %0d done %0d beats %0d timeout %0d expected 1 0 0 0",
                     err_cnt, done_cnt, obs_q.size(), burst_timed_out);
        end
        checks++;
        if (err_stall !== TMO || err_cyc_low !== 1'b1) begin
            errors++;
            $display("FAIL tmo_stall: stalls %0d bus_idle %b expected %0d 1", err_stall, err_cyc_low, TMO);
        end
        no_ack = 0;
        run_burst(1'b0, 26'h800, 0, 0);
        checks++;
        if (burst_timed_out || done_cnt !== 1 || obs_rd.size() !== 1) begin
            errors++;
            $display("FAIL tmo_recover: done %0d beats %0d expected 1 1", done_cnt, obs_rd.size());
        end else begin
            checks++;
            if (obs_rd[0] !== exp_rd[0]) begin
                errors++;
                $display("FAIL tmo_recover_data: got %h expected %h", obs_rd[0], exp_rd[0]);
            end
        end
    endtask

    task automatic test_random();
        logic          we;
        logic [AW-1:0] addr;
        int            len;
        stray_en = 1;
        for (int n = 0; n < 10; n++) begin
            we = 1'($urandom_range(0, 1));
            addr = AW'(32'h4000 + $urandom_range(0, 15) * BW);
            len = $urandom_range(0, 7);
            ack_delay = $urandom_range(0, 2);
            run_burst(we, addr, len, 2);
            checks++;
            if (burst_timed_out || obs_q.size() !== exp_q.size() || done_cnt !== 1 || err_cnt !== 0
                || done_n !== last_ack_n + 1) begin
                errors++;
                $display("FAIL rand%0d_ctrl: beats %0d done %0d err %0d expected %0d 1 0",
                         n, obs_q.size(), done_cnt, err_cnt, exp_q.size());
            end
            foreach (exp_q[i]) begin
                if (i < obs_q.size()) begin
                    checks++;
                    if (obs_q[i] !== exp_q[i]) begin
                        errors++;
                        $display("FAIL rand%0d_beat%0d: got %h expected %h", n, i, obs_q[i], exp_q[i]);
                    end
                end
            end
            foreach (exp_rd[i]) begin
                checks++;
                if (i >= obs_rd.size() || obs_rd[i] !== exp_rd[i]) begin
                    errors++;
                    $display("FAIL rand%0d_rd%0d: got %h expected %h", n, i,
                             (i < obs_rd.size()) ? obs_rd[i] : 32'h0, exp_rd[i]);
                end
            end
        end
        stray_en = 0;
    endtask

    task automatic test_reset_mid();
        ack_delay = 0;
        burst_timed_out = 0;
        send_cmd(1'b0, 26'h1000, 8'd200);
        repeat (5) tick();
        checks++;
        if (burst_timed_out || wb_cyc_o !== 1'b1 || wb_stb_o !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_running: cyc %b stb %b expected 1 1", wb_cyc_o, wb_stb_o);
        end
        #2;
        RESETN = 1'b0;
        #1;
        checks++;
        if ({wb_cyc_o, wb_stb_o, busy, rd_valid, cmd_ready} !== 5'd0) begin
            errors++;
            $display("FAIL rstmid_async: cyc/stb/busy/rd_valid/ready %b expected 00000",
                     {wb_cyc_o, wb_stb_o, busy, rd_valid, cmd_ready});
        end
        tick();
        RESETN = 1'b1;
        checks++;
        if (dbg_state_o !== 3'd0 || cmd_ready !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_idle: state %0d ready %b expected 0 0", dbg_state_o, cmd_ready);
        end
        tick();
        checks++;
        if (cmd_ready !== 1'b1 || wb_cyc_o !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_ready: ready %b cyc %b expected 1 0", cmd_ready, wb_cyc_o);
        end
        run_burst(1'b0, 26'h1000, 1, 0);
        checks++;
        if (burst_timed_out || done_cnt !== 1 || obs_rd.size() !== 2) begin
            errors++;
            $display("FAIL rstmid_after: done %0d beats %0d expected 1 2", done_cnt, obs_rd.size());
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_init_gate();
        test_single_write();
        test_write_read();
        test_wrap();
        test_timeout();
        test_random();
        test_reset_mid();
        repeat (3) tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/wb_burst_master.md
# wb_burst_master

Wishbone initiator that drives the SDRAM controller's Wishbone slave port from a simple command/stream interface. It turns one accepted command (start address, beat count, direction) into a classic-cycle incremental burst (CTI 010, last beat 111), feeds write beats from a valid/ready data stream and returns read beats on a valid-only stream. It sits between test traffic or an application engine and `sdrc_top`, on the `sys_clk` domain.

## Interface
- AW, 26, Wishbone byte-address width
- DW, 32, Wishbone data width
- BW, 4, byte lanes (DW/8); address step per beat
- TMO, 255, max cycles to wait for `wb_ack_i` on one beat before abort
- sys_clk  in  1  system clock; all logic on rising edge
- RESETN  in  1  reset; one clock; reset is asynchronous and active-low
- sdr_init_done  in  1  controller init complete; commands refused while low
- cmd_valid  in  1  command request
- cmd_ready  out  1  command accepted when valid&ready
- cmd_we  in  1  1 = write burst, 0 = read burst
- cmd_addr  in  AW  start byte address
- cmd_len  in  8  beats minus one (0..255 -> 1..256 beats)
- wr_data  in  DW  write beat data
- wr_valid  in  1  write beat available
- wr_ready  out  1  write beat taken when valid&ready
- rd_data  out  DW  read beat data
- rd_valid  out  1  one-cycle pulse per read beat; no backpressure
- busy  out  1  burst in progress
- done  out  1  one-cycle pulse, burst completed
- err  out  1  one-cycle pulse, burst aborted on timeout
- wb_cyc_o, wb_stb_o, wb_we_o  out  1 each  Wishbone cycle/strobe/write-enable
- wb_addr_o  out  AW  beat byte address
- wb_dat_o  out  DW  write data
- wb_sel_o  out  BW  byte selects, all ones during a cycle
- wb_cti_o  out  3  010 incrementing, 111 last beat
- wb_ack_i  in  1  slave acknowledge
- wb_dat_i  in  DW  slave read data

## Operation
- States: IDLE, WR_LOAD, WR_BEAT, RD_BEAT, FIN.
- IDLE: cmd_ready = sdr_init_done. On accept: latch addr, cnt = cmd_len, we; go WR_LOAD (we=1) or RD_BEAT (we=0). busy=1 in every non-IDLE state.
- WR_LOAD: wb_cyc_o=1, wb_stb_o=0, wr_ready=1; on wr_valid capture wr_data into wb_dat_o register, go WR_BEAT.
- WR_BEAT: wb_stb_o=1, wb_we_o=1; on ack: cnt==0 -> FIN, else cnt-1, addr+BW, -> WR_LOAD.
- RD_BEAT: wb_stb_o=1, wb_we_o=0 held across beats; each ack: rd_data<=wb_dat_i, rd_valid pulse, addr+BW, cnt-1; ack with cnt==0 -> FIN (stb drops same edge).
- FIN: cyc=stb=0, done=1 for one cycle, -> IDLE.
- wb_cti_o = 111 when cnt==0 else 010 (single beat = 111). wb_sel_o = all ones while cyc, else 0.
- Address: wb_addr_o = latched addr, incremented by BW per ack, modulo 2^AW (wraps to 0, no error).
- Timeout: watchdog counts cycles with stb=1 and no ack, clears on ack; reaching TMO -> cyc/stb/we drop next edge, err pulse one cycle, return IDLE, no done. Remaining write beats not consumed.
- sdr_init_done falling mid-burst is ignored; burst continues.
- Ack while stb=0 ignored.

## Timing
- Reset (async, any state): state IDLE; all outputs 0 (cmd_ready 0 until first clock with sdr_init_done=1), wb_cyc_o/stb 0 immediately, counters/addr/data cleared.
- Command accepted at edge N: read -> cyc/stb high from cycle N+1; write -> wr_ready high from N+1.
- Write beat captured at edge M -> stb high M+1; ack at edge K -> next wr_ready at K+1 (min 2 cycles/write beat).
- Read: continuous stb; 1 beat/cycle under zero-wait acks; rd_valid one cycle after each ack edge.
- done asserted cycle after last ack; cmd_ready again the following cycle.

## Test plan
- Reset: hold RESETN=0, toggle inputs -> all outputs 0; assert RESETN=0 mid read burst -> cyc/stb drop asynchronously, IDLE after release.
- Single write: sdr_init_done=1, cmd addr 0x100, len 0, we=1, wr_data 0xA5A5_0001 -> one beat, addr 0x100, cti 111, sel 0xF, done one cycle after ack.
- 4-beat write then read at 0x200 with wr_valid gaps and 2-cycle ack delay -> addrs 0x200/204/208/20C, cti 010,010,010,111; read returns same 4 words on rd_valid in order.
- cmd_valid with sdr_init_done=0 -> cmd_ready 0, no cyc; accepted first cycle after init_done rises.
- Slave never acks, TMO=255 -> err pulse after 255 stall cycles, cyc drops, no done, next command accepted.
- Wrap: cmd_addr 2^AW-8, len 3, read -> addrs max-7, max-3, 0, 4.
